// File: rtl/fifo_read_packer_pkg.sv
// Shared FSM state type and width helpers for the FIFO read-side byte packer.
package fifo_pack_pkg;

   typedef enum logic {COLLECT, FLUSH_PEND} pack_state_e;

   localparam int DEF_WIDTH      = 8;
   localparam int DEF_WORD_BYTES = 4;
   localparam int DEF_CNT_W      = 16;

   function automatic int nbytes_w(input int word_bytes);
      return $clog2(word_bytes + 1);
   endfunction

   function automatic int word_w(input int width, input int word_bytes);
      return width * word_bytes;
   endfunction

endpackage

// File: rtl/fifo_read_packer_if.sv
// Packer port bundle: FIFO show-ahead read side plus the valid/ready word output.
// out_parity exists only when PACKER_PARITY_EN is defined.
interface fifo_read_packer_if
   import fifo_pack_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int WORD_BYTES = DEF_WORD_BYTES,
   parameter int CNT_W      = DEF_CNT_W
);
   localparam int NB_W   = nbytes_w(WORD_BYTES);
   localparam int WORD_W = word_w(WIDTH, WORD_BYTES);

   logic [WIDTH-1:0]  fifo_data;
   logic              fifo_empty;
   logic              fifo_rd_en;
   logic              flush;
   logic [WORD_W-1:0] out_data;
   logic [NB_W-1:0]   out_nbytes;
   logic              out_valid;
   logic              out_ready;
   logic [CNT_W-1:0]  word_count;
`ifdef PACKER_PARITY_EN
   logic              out_parity;

   modport master (
      input  fifo_data, fifo_empty, flush, out_ready,
      output fifo_rd_en, out_data, out_nbytes, out_valid, word_count, out_parity
   );
   modport slave (
      output fifo_data, fifo_empty, flush, out_ready,
      input  fifo_rd_en, out_data, out_nbytes, out_valid, word_count, out_parity
   );
`else
   modport master (
      input  fifo_data, fifo_empty, flush, out_ready,
      output fifo_rd_en, out_data, out_nbytes, out_valid, word_count
   );
   modport slave (
      output fifo_data, fifo_empty, flush, out_ready,
      input  fifo_rd_en, out_data, out_nbytes, out_valid, word_count
   );
`endif

endinterface

// File: rtl/fifo_read_packer_pack_out_slot.sv
// Single-entry output register with valid/ready hold; optional parity under PACKER_PARITY_EN.
module pack_out_slot #(
   parameter int WORD_W = 32,
   parameter int NB_W   = 3
) (
   input  logic              rd_clk,
   input  logic              reset_n,
   input  logic              load,
   input  logic [WORD_W-1:0] load_data,
   input  logic [NB_W-1:0]   load_nbytes,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [WORD_W-1:0] out_data,
   output logic [NB_W-1:0]   out_nbytes,
`ifdef PACKER_PARITY_EN
   output logic              out_parity,
`endif
   output logic              slot_free
);
   logic              valid_reg;
   logic [WORD_W-1:0] data_reg;
   logic [NB_W-1:0]   nbytes_reg;

   assign slot_free = !valid_reg || out_ready;

   // The caller only raises load when slot_free, so a held word is never overwritten.
   always_ff @(posedge rd_clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_reg  <= 1'b0;
         data_reg   <= '0;
         nbytes_reg <= '0;
      end else if (load) begin
         valid_reg  <= 1'b1;
         data_reg   <= load_data;
         nbytes_reg <= load_nbytes;
      end else if (out_ready) begin
         valid_reg  <= 1'b0;
      end
   end

`ifdef PACKER_PARITY_EN
   logic parity_reg;

   always_ff @(posedge rd_clk or negedge reset_n) begin
      if (!reset_n)
         parity_reg <= 1'b0;
      else if (load)
         parity_reg <= ^load_data;
   end

   assign out_parity = parity_reg;
`endif

   assign out_valid  = valid_reg;
   assign out_data   = data_reg;
   assign out_nbytes = nbytes_reg;

endmodule

// File: rtl/fifo_read_packer.sv
// Pops bytes from a show-ahead FIFO and packs WORD_BYTES of them little-endian into words,
// with flush for partial tails. Optional out_parity via PACKER_PARITY_EN.
module fifo_read_packer
   import fifo_pack_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int WORD_BYTES = DEF_WORD_BYTES,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic               rd_clk,
   input  logic               reset_n,
   fifo_read_packer_if.master bus
);
   localparam int NB_W     = nbytes_w(WORD_BYTES);
   localparam int WORD_W   = word_w(WIDTH, WORD_BYTES);
   localparam int CNT_BITS = $clog2(WORD_BYTES);
   localparam int PART_W   = (WORD_BYTES - 1) * WIDTH;
   localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(WORD_BYTES - 1);

   pack_state_e         state_reg;
   logic [CNT_BITS-1:0] cnt_reg;
   logic [CNT_W-1:0]    word_count_reg;
   logic [PART_W-1:0]   partial_flat;
   logic                slot_free;
   logic                pop;
   logic                last_pop;
   logic                flush_emit;
   logic                load;
   logic [WORD_W-1:0]   load_data;
   logic [NB_W-1:0]     load_nbytes;

   assign bus.fifo_rd_en = reset_n && !bus.fifo_empty && (state_reg == COLLECT) && !bus.flush
                           && ((cnt_reg != LAST) || slot_free);
   assign pop        = bus.fifo_rd_en;
   assign last_pop   = pop && (cnt_reg == LAST);
   assign flush_emit = slot_free && (((state_reg == COLLECT) && bus.flush && (cnt_reg != '0))
                                     || (state_reg == FLUSH_PEND));
   assign load       = last_pop || flush_emit;

   // The final byte bypasses storage, so only WORD_BYTES-1 slices are registered; clearing
   // them on every emission makes the unused upper slices of a partial word read as zero.
   genvar gi;
   generate
      for (gi = 0; gi < WORD_BYTES - 1; gi++) begin : g_slice
         logic [WIDTH-1:0] byte_reg;

         always_ff @(posedge rd_clk or negedge reset_n) begin
            if (!reset_n)
               byte_reg <= '0;
            else if (load)
               byte_reg <= '0;
            else if (pop && (cnt_reg == CNT_BITS'(gi)))
               byte_reg <= bus.fifo_data;
         end

         assign partial_flat[gi*WIDTH +: WIDTH] = byte_reg;
      end
   endgenerate

   assign load_data   = last_pop ? {bus.fifo_data, partial_flat} : {{WIDTH{1'b0}}, partial_flat};
   assign load_nbytes = last_pop ? NB_W'(WORD_BYTES) : NB_W'(cnt_reg);

   always_ff @(posedge rd_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg      <= COLLECT;
         cnt_reg        <= '0;
         word_count_reg <= '0;
      end else begin
         if (load)
            word_count_reg <= word_count_reg + 1'b1;
         case (state_reg)
            COLLECT: begin
               if (load)
                  cnt_reg <= '0;
               else if (pop)
                  cnt_reg <= cnt_reg + 1'b1;
               else if (bus.flush && (cnt_reg != '0))
                  state_reg <= FLUSH_PEND;
            end
            FLUSH_PEND: begin
               if (flush_emit) begin
                  cnt_reg   <= '0;
                  state_reg <= COLLECT;
               end
            end
         endcase
      end
   end

   assign bus.word_count = word_count_reg;

   pack_out_slot #(
      .WORD_W (WORD_W),
      .NB_W   (NB_W)
   ) u_slot (
      .rd_clk      (rd_clk),
      .reset_n     (reset_n),
      .load        (load),
      .load_data   (load_data),
      .load_nbytes (load_nbytes),
      .out_ready   (bus.out_ready),
      .out_valid   (bus.out_valid),
      .out_data    (bus.out_data),
      .out_nbytes  (bus.out_nbytes),
`ifdef PACKER_PARITY_EN
      .out_parity  (bus.out_parity),
`endif
      .slot_free   (slot_free)
   );

endmodule

// File: tb/tb_fifo_read_packer.sv
// Directed bench for fifo_read_packer: stream, backpressure, flush, reset and counter wrap.
// out_parity checks are compiled only when PACKER_PARITY_EN is defined.
module tb_fifo_read_packer;
   import fifo_pack_pkg::*;

   localparam int WIDTH      = 8;
   localparam int WORD_BYTES = 4;
   // Narrow counter so the wrap is reachable in a short run.
   localparam int CNT_W      = 4;

   logic rd_clk  = 1'b0;
   logic reset_n = 1'b0;

   fifo_read_packer_if #(.WIDTH(WIDTH), .WORD_BYTES(WORD_BYTES), .CNT_W(CNT_W)) bus ();

   fifo_read_packer #(.WIDTH(WIDTH), .WORD_BYTES(WORD_BYTES), .CNT_W(CNT_W)) dut (
      .rd_clk  (rd_clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 rd_clk = ~rd_clk;

   // Show-ahead FIFO model
   logic [7:0] mem [0:63];
   int wr_ptr = 0;
   int rd_ptr = 0;
   int pops   = 0;
   int checks = 0;
   int errors = 0;
   int p0;

   assign bus.fifo_empty = (rd_ptr == wr_ptr);
   assign bus.fifo_data  = mem[rd_ptr[5:0]];

   always @(posedge rd_clk) begin
      if (bus.fifo_rd_en && !bus.fifo_empty) begin
         rd_ptr <= rd_ptr + 1;
         pops   <= pops + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) @(negedge rd_clk);
   endtask

   task automatic push(input logic [7:0] b);
      mem[wr_ptr[5:0]] = b;
      wr_ptr++;
   endtask

   initial begin
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      reset_n       = 1'b0;
      for (int i = 0; i < 4; i++) push(8'(8'h0A + i));
      tick(1);
      chk("rst_valid",  32'(bus.out_valid),  32'd0);
      chk("rst_data",   32'(bus.out_data),   32'd0);
      chk("rst_nbytes", 32'(bus.out_nbytes), 32'd0);
      chk("rst_wc",     32'(bus.word_count), 32'd0);
      chk("rst_rd_en",  32'(bus.fifo_rd_en), 32'd0);

      // Stream: one word with out_ready high
      reset_n = 1'b1;
      p0 = pops;
      #1;
      chk("s_rd_en_on", 32'(bus.fifo_rd_en), 32'd1);
      tick(3);
      chk("s_not_early", 32'(bus.out_valid), 32'd0);
      tick(1);
      chk("s_pops",   32'(pops - p0),        32'd4);
      chk("s_valid",  32'(bus.out_valid),    32'd1);
      chk("s_data",   32'(bus.out_data),     32'h0D0C0B0A);
      chk("s_nbytes", 32'(bus.out_nbytes),   32'd4);
      chk("s_wc",     32'(bus.word_count),   32'd1);
      chk("s_rd_off", 32'(bus.fifo_rd_en),   32'd0);
`ifdef PACKER_PARITY_EN
      chk("s_parity", 32'(bus.out_parity),   32'd0);
`endif
      tick(1);
      chk("s_drained", 32'(bus.out_valid), 32'd0);

      // Backpressure: 8 bytes, consumer stalled
      bus.out_ready = 1'b0;
      for (int i = 0; i < 8; i++) push(8'(8'h0A + i));
      p0 = pops;
      tick(5);
      chk("bp_hold1", 32'(bus.out_data), 32'h0D0C0B0A);
      tick(4);
      chk("bp_pops",  32'(pops - p0),        32'd7);
      chk("bp_rd_en", 32'(bus.fifo_rd_en),   32'd0);
      chk("bp_valid", 32'(bus.out_valid),    32'd1);
      chk("bp_hold2", 32'(bus.out_data),     32'h0D0C0B0A);
      chk("bp_wc",    32'(bus.word_count),   32'd2);
      bus.out_ready = 1'b1;
      #1;
      chk("bp_rd_resume", 32'(bus.fifo_rd_en), 32'd1);
      tick(1);
      chk("bp_b2b_valid", 32'(bus.out_valid),  32'd1);
      chk("bp_b2b_data",  32'(bus.out_data),   32'h11100F0E);
      chk("bp_b2b_wc",    32'(bus.word_count), 32'd3);
      tick(1);
      chk("bp_idle", 32'(bus.out_valid), 32'd0);

      // Flush with a free slot
      push(8'h0A);
      push(8'h0B);
      tick(2);
      bus.flush = 1'b1;
      push(8'h55);
      #1;
      chk("ff_rd_en", 32'(bus.fifo_rd_en), 32'd0);
      p0 = pops;
      tick(1);
      bus.flush = 1'b0;
      chk("ff_valid",  32'(bus.out_valid),  32'd1);
      chk("ff_data",   32'(bus.out_data),   32'h00000B0A);
      chk("ff_nbytes", 32'(bus.out_nbytes), 32'd2);
      chk("ff_wc",     32'(bus.word_count), 32'd4);
      chk("ff_nopop",  32'(pops - p0),      32'd0);
`ifdef PACKER_PARITY_EN
      chk("ff_parity", 32'(bus.out_parity), 32'd1);
`endif
      tick(1);
      chk("ff_after_pop", 32'(pops - p0),     32'd1);
      chk("ff_accepted",  32'(bus.out_valid), 32'd0);

      // Flush with a busy slot (cnt=1 holding 0x24)
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) push(8'(8'h21 + i));
      tick(4);
      chk("fb_word", 32'(bus.out_data),   32'h23222155);
      chk("fb_wc",   32'(bus.word_count), 32'd5);
      bus.flush = 1'b1;
      push(8'h30);
      tick(1);
      bus.flush = 1'b0;
      #1;
      chk("fb_pend_rd_en", 32'(bus.fifo_rd_en), 32'd0);
      chk("fb_pend_hold",  32'(bus.out_data),   32'h23222155);
      bus.flush = 1'b1;
      tick(1);
      bus.flush = 1'b0;
      chk("fb_pend_wc",  32'(bus.word_count), 32'd5);
      bus.out_ready = 1'b1;
      #1;
      chk("fb_pend_rd_en2", 32'(bus.fifo_rd_en), 32'd0);
      tick(1);
      chk("fb_valid",  32'(bus.out_valid),  32'd1);
      chk("fb_data",   32'(bus.out_data),   32'h00000024);
      chk("fb_nbytes", 32'(bus.out_nbytes), 32'd1);
      chk("fb_wc2",    32'(bus.word_count), 32'd6);
      p0 = pops;
      tick(1);
      chk("fb_resume_pop", 32'(pops - p0),     32'd1);
      chk("fb_accepted",   32'(bus.out_valid), 32'd0);

      // Reset mid-word with a word pending
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) push(8'(8'h31 + i));
      tick(4);
      chk("mr_word", 32'(bus.out_data),   32'h33323130);
      chk("mr_wc",   32'(bus.word_count), 32'd7);
      for (int i = 0; i < 4; i++) push(8'(8'h40 + i));
      reset_n = 1'b0;
      #1;
      chk("mr_valid",  32'(bus.out_valid),  32'd0);
      chk("mr_data",   32'(bus.out_data),   32'd0);
      chk("mr_nbytes", 32'(bus.out_nbytes), 32'd0);
      chk("mr_wc0",    32'(bus.word_count), 32'd0);
      chk("mr_rd_en",  32'(bus.fifo_rd_en), 32'd0);
      tick(1);
      reset_n       = 1'b1;
      bus.out_ready = 1'b1;
      tick(4);
      chk("mr_new_data", 32'(bus.out_data),   32'h43424140);
      chk("mr_new_nb",   32'(bus.out_nbytes), 32'd4);
      chk("mr_new_wc",   32'(bus.word_count), 32'd1);
      tick(1);

      // Flush with nothing collected
      bus.flush = 1'b1;
      tick(1);
      bus.flush = 1'b0;
      chk("f0_valid", 32'(bus.out_valid),  32'd0);
      chk("f0_wc",    32'(bus.word_count), 32'd1);
      tick(1);
      chk("f0_valid2", 32'(bus.out_valid), 32'd0);

      // Word counter wrap
      for (int i = 0; i < 56; i++) push(8'(i));
      tick(56);
      chk("wr_wc_max", 32'(bus.word_count), 32'hF);
      chk("wr_data",   32'(bus.out_data),   32'h37363534);
      for (int i = 0; i < 4; i++) push(8'(8'hA0 + i));
      tick(4);
      chk("wr_wc_wrap", 32'(bus.word_count), 32'd0);
      chk("wr_valid",   32'(bus.out_valid),  32'd1);
      chk("wr_last",    32'(bus.out_data),   32'hA3A2A1A0);
`ifdef PACKER_PARITY_EN
      chk("wr_parity",  32'(bus.out_parity), 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
